oc8051_ecc_scrub: RTL



---
 rtl/oc8051_ecc_scrub.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/oc8051_ecc_scrub.sv
// Background SECDED scrubber: walks the RAM, corrects single-bit errors and logs double-bit errors.
// Define OC8051_ECC_SCRUB_WRITEBACK_EN to write corrected words back; without it the block only detects.
module oc8051_ecc_scrub #(
  parameter int K        = 8,
  parameter int AW       = 8,
  parameter int INTERVAL = 1024,
  localparam int M0      = $clog2(K + 1),
  localparam int M1      = $clog2(K + 1 + M0),
  localparam int M2      = $clog2(K + 1 + M1),
  localparam int M       = $clog2(K + 1 + M2),
  localparam int N       = M + K
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [N:0]    mem_d_o,
  input  logic [N:0]    mem_q_i,
  input  logic          mem_ack_i,
  output logic [15:0]   corr_cnt_o,
  output logic          uncorr_o,
  output logic [AW-1:0] err_adr_o,
  output logic          pass_done_o,
  output logic          busy_o
);

  localparam int             TW       = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0]  TIMER_TC = TW'(INTERVAL - 1);
  localparam logic [M-1:0]   SYN_MAX  = M'(N);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CHK
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
    , WR
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] ptr_q;
  logic [N:0]    data_q;
  logic [15:0]   corr_cnt_q;
  logic          uncorr_q;
  logic [AW-1:0] err_adr_q;
  logic          pass_done_q;

  logic [M-1:0]  syn;
  logic          par;
  logic          clean;
  logic          correctable;
  logic          load_rd;
  logic          advance;
  logic          inc_cnt;
  logic          set_uncorr;
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
  logic [N:0]    corrected;
  logic          load_fix;
`endif

  // Syndrome bit i covers every codeword position j whose index has bit i set; p0 sits at bit 0.
  function automatic logic [M-1:0] syndrome(input logic [N:0] cw);
    logic [M-1:0] s;
    s = '0;
    for (int j = 1; j <= N; j++) begin
      for (int i = 0; i < M; i++) begin
        if (j[i]) s[i] = s[i] ^ cw[j];
      end
    end
    return s;
  endfunction

  assign syn         = syndrome(data_q);
  assign par         = ^data_q;
  assign clean       = !par && (syn == '0);
  assign correctable = par && (syn <= SYN_MAX);
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
  assign corrected   = data_q ^ ((N + 1)'(1) << syn);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    load_rd    = 1'b0;
    advance    = 1'b0;
    inc_cnt    = 1'b0;
    set_uncorr = 1'b0;
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
    load_fix   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en_i) begin
          if (timer_q == TIMER_TC) state_d = RD;
          else                     timer_d = timer_q + 1'b1;
        end
      end
      RD: begin
        if (mem_ack_i) begin
          load_rd = 1'b1;
          state_d = CHK;
        end
      end
      CHK: begin
        if (clean) begin
          advance = 1'b1;
          state_d = IDLE;
        end else if (correctable) begin
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
          load_fix = 1'b1;
          state_d  = WR;
`else
          inc_cnt  = 1'b1;
          advance  = 1'b1;
          state_d  = IDLE;
`endif
        end else begin
          set_uncorr = 1'b1;
          advance    = 1'b1;
          state_d    = IDLE;
        end
      end
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
      WR: begin
        if (mem_ack_i) begin
          inc_cnt = 1'b1;
          advance = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a same-cycle count increment or flag set; pointer is never cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      data_q      <= '0;
      corr_cnt_q  <= '0;
      uncorr_q    <= 1'b0;
      err_adr_q   <= '0;
      pass_done_q <= 1'b0;
    end else begin
      pass_done_q <= advance && (ptr_q == '1);
      if (advance) ptr_q <= ptr_q + 1'b1;
      if (load_rd) data_q <= mem_q_i;
`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
      else if (load_fix) data_q <= corrected;
`endif
      if (clr_i) begin
        corr_cnt_q <= '0;
        uncorr_q   <= 1'b0;
        err_adr_q  <= '0;
      end else begin
        if (inc_cnt && (corr_cnt_q != 16'hFFFF)) corr_cnt_q <= corr_cnt_q + 1'b1;
        if (set_uncorr) begin
          uncorr_q  <= 1'b1;
          err_adr_q <= ptr_q;
        end
      end
    end
  end

`ifdef OC8051_ECC_SCRUB_WRITEBACK_EN
  assign mem_req_o = (state_q == RD) || (state_q == WR);
  assign mem_we_o  = (state_q == WR);
`else
  assign mem_req_o = (state_q == RD);
  assign mem_we_o  = 1'b0;
`endif
  assign mem_adr_o   = ptr_q;
  assign mem_d_o     = data_q;
  assign corr_cnt_o  = corr_cnt_q;
  assign uncorr_o    = uncorr_q;
  assign err_adr_o   = err_adr_q;
  assign pass_done_o = pass_done_q;
  assign busy_o      = (state_q != IDLE);

endmodule
